// File: rtl/display_mux.sv
// Multi-source 7-segment display multiplexer with per-digit blink masks and
// an optional idle fallback to source 0.
module display_mux #(
  parameter int N_DIGITS   = 6,
  parameter int N_SRC      = 2,
  parameter int BLINK_HALF = 25_000_000,
  parameter int TIMEOUT    = 0,
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            en,
  input  logic [N_SRC*N_DIGITS*4-1:0] bcd_in,
  input  logic [N_SRC*N_DIGITS-1:0]   blink_in,
  output logic [N_DIGITS*7-1:0]       hex_out,
  output logic [SW-1:0]               active_src
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TO_EN      = (TIMEOUT > 0) && (N_SRC > 1);

  logic [N_SRC*N_DIGITS*4-1:0] digits_r;
  logic [N_SRC*N_DIGITS-1:0]   mask_r;
  logic [SW-1:0]               active_src_r;
  logic [BW-1:0]               blink_cnt_r;
  logic                        phase_r;
  logic [TW-1:0]               idle_r;

  logic                        any_en_s;
  logic [SW-1:0]               lowest_s;
  logic                        fire_s;
  logic [N_DIGITS*4-1:0]       sel_digits_s;
  logic [N_DIGITS-1:0]         sel_mask_s;
  logic [N_DIGITS*7-1:0]       hex_s;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0111111;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Lowest-index asserted enable, scanned high to low so the lowest wins.
  always_comb begin
    lowest_s = '0;
    for (int s = N_SRC - 1; s >= 0; s--) begin
      if (en[s]) begin
        lowest_s = SW'(s);
      end else begin
        lowest_s = lowest_s;
      end
    end
  end

  assign any_en_s = |en;
  // Fallback only when nothing is being captured this edge: capture wins.
  assign fire_s   = TO_EN && !any_en_s && (active_src_r != '0) && (idle_r == TO_LAST);

  // Per-source digit and blink-mask storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      digits_r <= '1;
      mask_r   <= '0;
    end else begin
      for (int s = 0; s < N_SRC; s++) begin
        if (en[s]) begin
          digits_r[s*N_DIGITS*4 +: N_DIGITS*4] <= bcd_in[s*N_DIGITS*4 +: N_DIGITS*4];
          mask_r[s*N_DIGITS +: N_DIGITS]       <= blink_in[s*N_DIGITS +: N_DIGITS];
        end
      end
    end
  end

  // Displayed-source selection with idle fallback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_src_r <= '0;
    end else if (any_en_s) begin
      active_src_r <= lowest_s;
    end else if (fire_s) begin
      active_src_r <= '0;
    end else begin
      active_src_r <= active_src_r;
    end
  end

  // Idle counter: runs only while a non-zero source is shown without captures.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_r <= '0;
    end else if (any_en_s || fire_s || !TO_EN) begin
      idle_r <= '0;
    end else if (active_src_r != '0) begin
      idle_r <= idle_r + TW'(1);
    end else begin
      idle_r <= idle_r;
    end
  end

  // Free-running blink timebase; captures never touch it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      phase_r     <= ~phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
      phase_r     <= phase_r;
    end
  end

  // Pick the active source's digits and mask.
  always_comb begin
    sel_digits_s = digits_r[int'(active_src_r)*N_DIGITS*4 +: N_DIGITS*4];
    sel_mask_s   = mask_r[int'(active_src_r)*N_DIGITS +: N_DIGITS];
  end

  // Segment decode with blink blanking; reset forces every segment off.
  always_comb begin
    hex_s = '1;
    if (!rst) begin
      hex_s = '1;
    end else begin
      for (int d = 0; d < N_DIGITS; d++) begin
        if (phase_r && sel_mask_s[d]) begin
          hex_s[d*7 +: 7] = 7'b1111111;
        end else begin
          hex_s[d*7 +: 7] = seg7(sel_digits_s[d*4 +: 4]);
        end
      end
    end
  end

  assign hex_out    = hex_s;
  assign active_src = active_src_r;

endmodule

// File: tb/tb_display_mux.sv
// Directed self-checking bench for display_mux (6 digits, 3 sources,
// blink half-period 4, timeout 8).
module tb_display_mux;

  localparam int ND = 6;
  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   en;
  logic [NS*ND*4-1:0] bcd_in;
  logic [NS*ND-1:0]   blink_in;
  logic [ND*7-1:0] hex_out;
  logic [1:0]      active_src;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  logic m_phase = 1'b0;

  display_mux #(.N_DIGITS(6), .N_SRC(3), .BLINK_HALF(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .blink_in(blink_in),
    .hex_out(hex_out), .active_src(active_src)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0111111;
      default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] all_digit(input logic [3:0] v);
    logic [41:0] r;
    for (int d = 0; d < ND; d++) r[d*7 +: 7] = seg(v);
    return r;
  endfunction

  function automatic logic [41:0] one_to_six();
    logic [41:0] r;
    for (int d = 0; d < ND; d++) r[d*7 +: 7] = seg(4'(d + 1));
    return r;
  endfunction

  task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; the bench's own blink-phase model advances with it.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_cnt = 0; m_phase = 1'b0;
    end else if (m_cnt == 3) begin
      m_cnt = 0; m_phase = ~m_phase;
    end else begin
      m_cnt++;
    end
    #1;
  endtask

  task automatic load(input int s, input logic [3:0] v);
    for (int d = 0; d < ND; d++) bcd_in[(s*ND+d)*4 +: 4] = v;
  endtask

  task automatic load_seq0();
    for (int d = 0; d < ND; d++) bcd_in[d*4 +: 4] = 4'(d + 1);
  endtask

  initial begin
    rst = 1'b0; en = 3'b000; bcd_in = '0; blink_in = '0;
    #1;
    check("hex_in_reset_pre_edge", hex_out, {42{1'b1}});
    tick(); tick(); tick();
    check("hex_in_reset", hex_out, {42{1'b1}});
    check("active_in_reset", 42'(active_src), 42'd0);

    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("blank_after_release", hex_out, {42{1'b1}});
    end
    check("active_after_release", 42'(active_src), 42'd0);

    // Capture source 0 with digits 1..6, then change inputs without enable.
    load_seq0(); en = 3'b001;
    tick(); en = 3'b000;
    check("capture_src0", hex_out, one_to_six());
    check("capture_src0_active", 42'(active_src), 42'd0);
    load(0, 4'h8); load(1, 4'h3); load(2, 4'h2); blink_in = '1;
    tick(); tick(); tick();
    check("hold_no_en", hex_out, one_to_six());
    blink_in = '0;

    // Simultaneous capture of sources 1 and 2.
    load(1, 4'hA); load(2, 4'h9); en = 3'b110;
    tick(); en = 3'b000;
    check("simul_active", 42'(active_src), 42'd1);
    check("simul_dashes", hex_out, all_digit(4'hA));
    en = 3'b100;
    tick(); en = 3'b000;
    check("src2_active", 42'(active_src), 42'd2);
    check("src2_nines", hex_out, all_digit(4'h9));

    // Blink on HEX0 of source 0.
    load_seq0(); blink_in = '0; blink_in[0] = 1'b1; en = 3'b001;
    tick(); en = 3'b000;
    for (int i = 0; i < 16; i++) begin
      check("blink_hex0", 42'(hex_out[6:0]), m_phase ? 42'h7F : 42'(seg(4'h1)));
      check("blink_steady", 42'(hex_out[41:7]), 42'(one_to_six() >> 7));
      tick();
    end
    blink_in = '0; en = 3'b001;
    tick(); en = 3'b000;

    // Timeout fallback after 8 idle edges.
    load(2, 4'h8); en = 3'b100;
    tick(); en = 3'b000;
    check("to_start_active", 42'(active_src), 42'd2);
    for (int i = 0; i < 7; i++) tick();
    check("to_before_fire", 42'(active_src), 42'd2);
    check("to_before_fire_hex", hex_out, all_digit(4'h8));
    tick();
    check("to_fired_active", 42'(active_src), 42'd0);
    check("to_fired_hex", hex_out, one_to_six());

    // An enable pulse at idle edge 7 restarts the timeout.
    en = 3'b100;
    tick(); en = 3'b000;
    for (int i = 0; i < 6; i++) tick();
    en = 3'b100;
    tick(); en = 3'b000;
    for (int i = 0; i < 7; i++) tick();
    check("to_restart_no_fire", 42'(active_src), 42'd2);
    tick();
    check("to_restart_fired", 42'(active_src), 42'd0);

    // Reset mid-timeout coinciding with a source-1 capture.
    en = 3'b100;
    tick(); en = 3'b000;
    tick(); tick(); tick();
    rst = 1'b0; load(1, 4'h5); en = 3'b010;
    tick();
    check("rst_mid_hex", hex_out, {42{1'b1}});
    check("rst_mid_active", 42'(active_src), 42'd0);
    rst = 1'b1; en = 3'b000;
    tick();
    check("rst_mid_cleared_hex", hex_out, {42{1'b1}});
    check("rst_mid_cleared_active", 42'(active_src), 42'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
